// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32/64 M-extension execute unit.
// Multiplies with a radix-2 shift-add loop and divides with a restoring
// loop, one bit per clock. Operands are reduced to magnitudes at accept and
// the sign is reapplied once, when the final result is registered.
// Divide-by-zero and signed overflow finish on a one-cycle fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ONE      = XLEN'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;

  // Operation context captured at accept
  logic [2:0]      op_q;
  logic            neg_q;
  logic [CW-1:0]   counter;

  // mcand_q is the multiplicand for multiplies and the divisor for divides
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;

  // Accept-time decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            neg_res;
  logic            b_zero;
  logic            overflow;
  logic            fast;
  logic [XLEN-1:0] fast_value;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_next;
  logic [XLEN:0]     div_shifted;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_signed;
  logic [XLEN-1:0]   rem_signed;
  logic [XLEN-1:0]   final_value;

  // Decode the incoming request: operand signedness, magnitudes, the sign
  // to restore at the end, and whether the fast path applies
  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a   = a_signed && a[XLEN-1];
    sign_b   = b_signed && b[XLEN-1];
    abs_a    = sign_a ? (~a) + ONE : a;
    abs_b    = sign_b ? (~b) + ONE : b;
    // Remainder takes the dividend's sign; product and quotient the xor
    neg_res  = (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
    b_zero   = (b == '0);
    overflow = is_div && !funct3[0] && (a == MOST_NEG) && (b == '1);
    fast     = is_div && (b_zero || overflow);
    // Divide-by-zero is checked first so it wins over overflow
    if (b_zero) begin
      fast_value = funct3[1] ? a : '1;
    end else begin
      fast_value = funct3[1] ? '0 : a;
    end
  end

  // One shift-add multiply step and one restoring divide step, plus the
  // sign-corrected result that would be registered if this is the last step
  always_comb begin
    mul_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                  (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next   = {mul_sum, prod_q[XLEN-1:1]};

    div_shifted = {rem_q, quo_q[XLEN-1]};
    div_diff    = div_shifted - {1'b0, mcand_q};
    if (!div_diff[XLEN]) begin
      rem_next = div_diff[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = div_shifted[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end

    prod_signed = neg_q ? (~prod_next) + (2*XLEN)'(1) : prod_next;
    quo_signed  = neg_q ? (~quo_next) + ONE : quo_next;
    rem_signed  = neg_q ? (~rem_next) + ONE : rem_next;

    case (op_q)
      3'b000:                 final_value = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_value = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_value = quo_signed;
      default:                final_value = rem_signed;
    endcase
  end

  // Control FSM and datapath registers; busy, done and result are registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= funct3;
            neg_q   <= neg_res;
            mcand_q <= is_div ? abs_b : abs_a;
            prod_q  <= {{XLEN{1'b0}}, abs_b};
            rem_q   <= '0;
            quo_q   <= abs_a;
            counter <= CNT_INIT;
            if (fast) begin
              result <= fast_value;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state  <= CALC;
              busy   <= 1'b1;
              done   <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        CALC: begin
          prod_q  <= prod_next;
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          counter <= counter - CNT_ONE;
          if (counter == CNT_ONE) begin
            result <= final_value;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit at XLEN=32 and XLEN=8.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;

  logic        start32;
  logic [2:0]  f3_32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [31:0] result32;

  logic        start8;
  logic [2:0]  f3_8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  result8;

  int total;
  int bad;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk    (clk),
    .reset  (reset),
    .start  (start32),
    .funct3 (f3_32),
    .a      (a32),
    .b      (b32),
    .busy   (busy32),
    .done   (done32),
    .result (result32)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk    (clk),
    .reset  (reset),
    .start  (start8),
    .funct3 (f3_8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .result (result8)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one op in cycle 0, then watch until done, checking latency,
  // number of busy cycles and the result
  task automatic applyStimulus(input string tag, input bit narrow,
                               input logic [2:0] f3, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] exp_res,
                               input int exp_cycle, input int exp_busy);
    int          cyc;
    int          busy_cnt;
    bit          seen;
    logic [31:0] res;
    @(negedge clk);
    if (narrow) begin
      start8 = 1'b1;
      f3_8   = f3;
      a8     = av[7:0];
      b8     = bv[7:0];
    end else begin
      start32 = 1'b1;
      f3_32   = f3;
      a32     = av;
      b32     = bv;
    end
    cyc      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    res      = '0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start32 = 1'b0;
      start8  = 1'b0;
      if (narrow) begin
        if (busy8) busy_cnt++;
        if (done8) begin
          seen = 1'b1;
          res  = {24'd0, result8};
        end
      end else begin
        if (busy32) busy_cnt++;
        if (done32) begin
          seen = 1'b1;
          res  = result32;
        end
      end
    end
    checkOutput({tag, "/done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "/done_cycle"}, 32'(cyc), 32'(exp_cycle));
    checkOutput({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    checkOutput({tag, "/result"}, res, exp_res);
  endtask

  initial begin
    int          done_cnt;
    int          first_done;
    int          second_done;
    logic [31:0] first_res;
    logic [31:0] second_res;

    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    start32 = 1'b0;
    f3_32   = 3'b000;
    a32     = '0;
    b32     = '0;
    start8  = 1'b0;
    f3_8    = 3'b000;
    a8      = '0;
    b8      = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset/busy", 32'(busy32), 32'd0);
    checkOutput("reset/done", 32'(done32), 32'd0);
    checkOutput("reset/result", result32, 32'd0);
    checkOutput("reset/result8", {24'd0, result8}, 32'd0);
    reset = 1'b1;

    // Full-latency multiplies and divides
    applyStimulus("mul",     1'b0, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 32);
    applyStimulus("mulh",    1'b0, 3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 32);
    applyStimulus("mulhu",   1'b0, 3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33, 32);
    applyStimulus("mulhsu2", 1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32);
    applyStimulus("mulhu2",  1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
    applyStimulus("mul2",    1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32);
    applyStimulus("mul_b0",  1'b0, 3'b000, 32'd1234, 32'd0, 32'd0, 33, 32);
    applyStimulus("div",     1'b0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 32);
    applyStimulus("rem",     1'b0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 32);
    applyStimulus("divu",    1'b0, 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, 32);
    applyStimulus("remu",    1'b0, 3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 33, 32);
    applyStimulus("div_nb",  1'b0, 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, 32);
    applyStimulus("rem_nb",  1'b0, 3'b110, 32'd100, 32'hFFFFFFF9, 32'd2, 33, 32);

    // Fast-path cases: done in cycle 1, busy never asserts
    applyStimulus("div_z",   1'b0, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    applyStimulus("rem_z",   1'b0, 3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
    applyStimulus("divu_z",  1'b0, 3'b101, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1, 0);
    applyStimulus("remu_z",  1'b0, 3'b111, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, 0);
    applyStimulus("div_ovf", 1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    applyStimulus("rem_ovf", 1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);
    applyStimulus("divu_big",1'b0, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 32);

    // Start while busy is ignored; restart in the DONE cycle runs back-to-back
    @(negedge clk);
    start32 = 1'b1;
    f3_32   = 3'b000;
    a32     = 32'd3;
    b32     = 32'd4;
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    first_res   = '0;
    second_res  = '0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      start32 = 1'b0;
      if (done32) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = cyc;
          first_res  = result32;
        end else if (done_cnt == 2) begin
          second_done = cyc;
          second_res  = result32;
        end
      end
      if (cyc == 34) checkOutput("b2b/busy_after_restart", 32'(busy32), 32'd1);
      if (cyc == 50) checkOutput("b2b/result_held", result32, 32'd12);
      if (cyc == 5) begin
        start32 = 1'b1;
        f3_32   = 3'b001;
        a32     = 32'd9;
        b32     = 32'd9;
      end else if (cyc == 33 && done32) begin
        start32 = 1'b1;
        f3_32   = 3'b000;
        a32     = 32'd5;
        b32     = 32'd6;
      end
    end
    checkOutput("b2b/first_cycle", 32'(first_done), 32'd33);
    checkOutput("b2b/first_result", first_res, 32'd12);
    checkOutput("b2b/second_cycle", 32'(second_done), 32'd66);
    checkOutput("b2b/second_result", second_res, 32'd30);
    checkOutput("b2b/done_count", 32'(done_cnt), 32'd2);

    // Reset in the middle of a divide discards it
    @(negedge clk);
    start32 = 1'b1;
    f3_32   = 3'b100;
    a32     = 32'd100;
    b32     = 32'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start32 = 1'b0;
      if (cyc == 10) reset = 1'b0;
    end
    @(negedge clk);
    checkOutput("rst_mid/busy", 32'(busy32), 32'd0);
    checkOutput("rst_mid/done", 32'(done32), 32'd0);
    checkOutput("rst_mid/result", result32, 32'd0);
    reset    = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done32) done_cnt++;
    end
    checkOutput("rst_mid/no_done", 32'(done_cnt), 32'd0);
    checkOutput("rst_mid/result_after", result32, 32'd0);

    // Narrow instance
    applyStimulus("x8_divu", 1'b1, 3'b101, 32'd200, 32'd7, 32'd28, 9, 8);
    applyStimulus("x8_remu", 1'b1, 3'b111, 32'd200, 32'd7, 32'd4, 9, 8);
    applyStimulus("x8_mul",  1'b1, 3'b000, 32'hFD, 32'd7, 32'hEB, 9, 8);
    applyStimulus("x8_mulh", 1'b1, 3'b001, 32'hFD, 32'd7, 32'hFF, 9, 8);
    applyStimulus("x8_ovf",  1'b1, 3'b100, 32'h80, 32'hFF, 32'h80, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
